// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared accumulator/drain types, sizes and the int8 ReLU helper
package tpu_pkg;

  localparam int DATA_NUM   = 16;
  localparam int OUT_DW     = 8;
  localparam int ADDR_W     = 4;
  localparam int ROW_W      = DATA_NUM * OUT_DW;
  localparam int FIFO_DEPTH = 2;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } drain_state_t;

  // Negative int8 lanes clamp to zero; the sign bit alone decides.
  function automatic row_t relu_row(input row_t r);
    row_t o;
    for (int i = 0; i < DATA_NUM; i++) begin
      o[i*OUT_DW +: OUT_DW] = r[i*OUT_DW + OUT_DW - 1] ? '0 : r[i*OUT_DW +: OUT_DW];
    end
    return o;
  endfunction

endpackage

// File: rtl/acc_drain_ctrl_if.sv
// rtl/acc_drain_ctrl_if.sv - row stream from the drain stage toward the unified buffer
interface acc_drain_ctrl_if;

  logic            m_valid;
  logic            m_ready;
  logic            m_last;
  tpu_pkg::row_t   m_data;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/acc_drain_skid_fifo.sv
// rtl/acc_drain_skid_fifo.sv - 2-entry skid FIFO holding {last, row}; head is presented combinationally
module acc_drain_skid_fifo
  import tpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [ROW_W:0]   wdata,
  output logic [ROW_W:0]   rdata,
  output logic [1:0]       count
);

  logic [ROW_W:0] mem [FIFO_DEPTH];
  logic           wr_ptr;
  logic           rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Empty FIFO presents zero so the stream data is clean outside valid beats.
  assign rdata = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/acc_drain_ctrl.sv
// rtl/acc_drain_ctrl.sv - accumulator drain FSM: credit-gated reads streamed out through a skid FIFO
// Optional ACC_DRAIN_RELU_EN clamps negative int8 lanes to zero at FIFO write.
module acc_drain_ctrl
  import tpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   row_cnt,
  output logic              busy,
  output logic              done,
  output logic              acc_enb,
  output logic [ADDR_W-1:0] acc_addrb,
  input  row_t              acc_doutb,
  acc_drain_ctrl_if.master  m
);

  drain_state_t      state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   rows_q;
  logic [ADDR_W:0]   issued;
  logic              inflight;
  logic              inflight_last;
  logic              pop;
  logic              issue_last;
  logic [1:0]        fifo_count;
  logic [2:0]        occupancy;
  logic [ROW_W:0]    fifo_rdata;
  row_t              row_in;

  assign pop        = m.m_valid & m.m_ready;
  // Rows held or still in the read pipe after this cycle's pop; keeps total at most 2.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign cur_addr   = base_q + issued[ADDR_W-1:0];
  assign issue_last = (issued == rows_q - 1'b1);
  assign acc_enb    = (state == ISSUE) && (occupancy < 3'd2);
  assign acc_addrb  = acc_enb ? cur_addr : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      base_q <= '0;
      rows_q <= '0;
      issued <= '0;
      addr_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            rows_q <= row_cnt;
            issued <= '0;
            if (row_cnt == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
              busy  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (acc_enb) begin
            issued <= issued + 1'b1;
            addr_q <= cur_addr;
            if (issue_last) begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (pop && m.m_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // The last-row tag rides alongside the read so it lands in the FIFO with its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= acc_enb;
      inflight_last <= acc_enb & issue_last;
    end
  end

`ifdef ACC_DRAIN_RELU_EN
  assign row_in = relu_row(acc_doutb);
`else
  assign row_in = acc_doutb;
`endif

  acc_drain_skid_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (pop),
    .wdata ({inflight_last, row_in}),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign m.m_valid = (fifo_count != 2'd0);
  assign m.m_last  = fifo_rdata[ROW_W];
  assign m.m_data  = fifo_rdata[ROW_W-1:0];

endmodule

// File: tb/tb_acc_drain_ctrl.sv
// tb/tb_acc_drain_ctrl.sv - randomized drain bench with a cycle-level behavioural model and literal pins
module tb_acc_drain_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   base_addr;
  logic [4:0]   row_cnt;
  logic         busy;
  logic         done;
  logic         acc_enb;
  logic [3:0]   acc_addrb;
  logic [127:0] acc_doutb;

  acc_drain_ctrl_if ifc ();

  acc_drain_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .row_cnt   (row_cnt),
    .busy      (busy),
    .done      (done),
    .acc_enb   (acc_enb),
    .acc_addrb (acc_addrb),
    .acc_doutb (acc_doutb),
    .m         (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] mem [16];
  always @(posedge clk) if (acc_enb) acc_doutb <= mem[acc_addrb];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [127:0] relu_ref(input logic [127:0] r);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      o[i*8 +: 8] = ($signed(r[i*8 +: 8]) < 0) ? 8'h00 : r[i*8 +: 8];
    end
    return o;
  endfunction

  // Model: a drain of n rows from base b; row j is mem[(b+j)%16]; reads become visible 2 cycles after issue.
  bit  act, d_now, d_was, busy_e, v_exp, pop_e, enb_e;
  int  n_m, b_m, k_m, p_m, avail;
  int  iss_t[$];
  int  dut_enb_total, dut_pop_total;
  int  addr_log[$];
  logic [127:0] beat_log[$];
  bit  last_log[$];
  int  start_cyc, done_cyc, done_cnt;

  function automatic logic [127:0] exp_row(input int j);
    logic [127:0] r;
    r = mem[(b_m + j) % 16];
`ifdef ACC_DRAIN_RELU_EN
    r = relu_ref(r);
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_acc_enb", acc_enb, 0);
      chk("rst_acc_addrb", acc_addrb, 0);
      chk("rst_m_valid", ifc.m_valid, 0);
      chk("rst_m_data", ifc.m_data, 0);
      chk("rst_m_last", ifc.m_last, 0);
      act = 0; d_now = 0; k_m = 0; p_m = 0; n_m = 0;
      iss_t.delete();
      dut_enb_total = 0; dut_pop_total = 0;
    end else begin
      avail = 0;
      foreach (iss_t[i]) if (iss_t[i] <= cyc - 2) avail++;
      v_exp  = (avail > p_m);
      pop_e  = v_exp && ifc.m_ready;
      enb_e  = act && (k_m < n_m) && ((k_m - p_m - int'(pop_e)) < 2);
      busy_e = act;
      chk("busy", busy, busy_e);
      chk("done", done, d_now);
      chk("m_valid", ifc.m_valid, v_exp);
      chk("acc_enb", acc_enb, enb_e);
      if (enb_e) chk("acc_addrb", acc_addrb, (b_m + k_m) % 16);
      if (v_exp) begin
        chk("m_data", ifc.m_data, exp_row(p_m));
        chk("m_last", ifc.m_last, p_m == n_m - 1);
      end
      if (acc_enb) begin
        addr_log.push_back(int'(acc_addrb));
        dut_enb_total++;
      end
      if (ifc.m_valid && ifc.m_ready) begin
        beat_log.push_back(ifc.m_data);
        last_log.push_back(ifc.m_last);
        dut_pop_total++;
      end
      chk("buffered_le_2", (dut_enb_total - dut_pop_total) <= 2, 1);
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end
      d_was = d_now;
      d_now = 0;
      if (enb_e) begin
        iss_t.push_back(cyc);
        k_m++;
      end
      if (pop_e) begin
        p_m++;
        if (p_m == n_m) begin
          act = 0;
          d_now = 1;
        end
      end
      if (start && !busy_e && !d_was) begin
        start_cyc = cyc;
        b_m = int'(base_addr);
        n_m = int'(row_cnt);
        k_m = 0; p_m = 0;
        iss_t.delete();
        if (n_m == 0) d_now = 1;
        else act = 1;
      end
    end
  end

  int mode = 0;
  int rc = 0;
  initial begin
    ifc.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1:       ifc.m_ready = (rc % 4 == 0) || (rc % 4 == 3);
        2:       ifc.m_ready = 1'($urandom_range(0, 1));
        default: ifc.m_ready = 1'b1;
      endcase
      rc++;
    end
  end

  task automatic clear_logs();
    addr_log.delete();
    beat_log.delete();
    last_log.delete();
  endtask

  task automatic run_drain(input int b, input int n, input bit extra);
    int d0;
    bit seen;
    clear_logs();
    d0 = done_cnt;
    seen = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b[3:0]; row_cnt = n[4:0];
    @(posedge clk); #1;
    if (extra) begin
      base_addr = b[3:0] + 4'd5; row_cnt = 5'd3;
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(posedge clk);
      if (done_cnt != d0) seen = 1;
    end
    if (!seen) chk("drain_timeout", 0, 1);
  endtask

  task automatic check_addrs(input string tag, input int b, input int n);
    chk({tag, "_n_reads"}, addr_log.size(), n);
    for (int i = 0; i < n && i < addr_log.size(); i++) chk({tag, "_addr"}, addr_log[i], (b + i) % 16);
  endtask

  task automatic check_beats(input string tag, input int b, input int n);
    chk({tag, "_n_beats"}, beat_log.size(), n);
    for (int i = 0; i < n && i < beat_log.size(); i++) begin
      chk({tag, "_lane0"}, beat_log[i][7:0], (b + i) % 16);
      chk({tag, "_last"}, last_log[i], i == n - 1);
    end
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; row_cnt = '0;
    for (int r = 0; r < 16; r++) begin
      mem[r] = {$urandom, $urandom, $urandom, 24'($urandom), 8'(r)};
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    mode = 0;
    run_drain(3, 4, 0);
    check_addrs("t1", 3, 4);
    check_beats("t1", 3, 4);
    chk("t1_done_latency", done_cyc - start_cyc, 7);

    run_drain(14, 4, 0);
    check_addrs("wrap", 14, 4);
    check_beats("wrap", 14, 4);

    mode = 1;
    run_drain(0, 16, 0);
    check_addrs("bp16", 0, 16);
    check_beats("bp16", 0, 16);

    mode = 0;
    run_drain(5, 0, 0);
    chk("zero_reads", addr_log.size(), 0);
    chk("zero_beats", beat_log.size(), 0);
    chk("zero_done_latency", done_cyc - start_cyc, 1);

    clear_logs();
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 4'd0; row_cnt = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && beat_log.size() < 2; i++) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    chk("rst_no_done", done_cnt, d0);
    run_drain(0, 2, 0);
    check_beats("after_rst", 0, 2);

    mem[7][31:0] = 32'h7F00FF80;
    run_drain(7, 3, 1);
    chk("relu_n_beats", beat_log.size(), 3);
    if (beat_log.size() > 0) begin
`ifdef ACC_DRAIN_RELU_EN
      chk("relu_lanes", beat_log[0][31:0], 32'h7F000000);
`else
      chk("relu_lanes", beat_log[0][31:0], 32'h7F00FF80);
`endif
    end

    for (int t = 0; t < 25; t++) begin
      int b, n;
      for (int r = 0; r < 16; r++) mem[r] = {$urandom, $urandom, $urandom, $urandom};
      mode = $urandom_range(0, 2);
      b = $urandom_range(0, 15);
      n = $urandom_range(0, 16);
      run_drain(b, n, 1'($urandom_range(0, 1)));
      chk("rand_n_beats", beat_log.size(), n);
      check_addrs("rand", b, n);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1);
  end

endmodule
